instr_encoder: RTL

// - Inverse of the core's opcode decoder: takes a field-level instruction description
//   (class, rd, rs1, rs2, funct3, imm) and packs it into a 32-bit RV32I instruction word.
// - Writes packed words sequentially into instruction memory. Used for boot/self-test program

---
 rtl/rv_isa_pkg.sv | 37 +++
 rtl/rv_pack.sv | 52 +++++
 rtl/instr_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding definitions: instruction classes, major opcodes,
// canonical NOP word and the encoder's FSM state type.
package rv_isa_pkg;

  typedef enum logic [3:0] {
    CLS_ALU   = 4'd0,
    CLS_ALUI  = 4'd1,
    CLS_BR    = 4'd2,
    CLS_LOAD  = 4'd3,
    CLS_STORE = 4'd4,
    CLS_JALR  = 4'd5,
    CLS_JAL   = 4'd6,
    CLS_LUI   = 4'd7,
    CLS_AUIPC = 4'd8,
    CLS_NOP   = 4'd9
  } enc_class_t;

  localparam logic [6:0] OPC_ALU   = 7'b0110011;
  localparam logic [6:0] OPC_ALUI  = 7'b0010011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/rv_pack.sv
// Combinational packer: instruction class plus fields -> 32-bit RV32I word.
// Flags classes outside the table and branch/jump offsets that are not
// 2-byte aligned; the word is don't-care when illegal is set.
module rv_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  in_class,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  enc_class_t cls;
  logic       is_shift;

  assign cls      = enc_class_t'(in_class);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Field placement per instruction format; bits above each field width drop out.
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (cls)
      CLS_ALU:   word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OPC_ALU};
      CLS_ALUI: begin
        if (is_shift) word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_ALUI};
        else          word = {imm[11:0], rs1, funct3, rd, OPC_ALUI};
      end
      CLS_BR: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BR};
        illegal = imm[0];
      end
      CLS_LOAD:  word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLS_STORE: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      CLS_JALR:  word = {imm[11:0], rs1, funct3, rd, OPC_JALR};
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = imm[0];
      end
      CLS_LUI:   word = {imm[31:12], rd, OPC_LUI};
      CLS_AUIPC: word = {imm[31:12], rd, OPC_AUIPC};
      CLS_NOP:   word = NOP_WORD;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field-level instruction descriptions and writes
// the packed words sequentially into instruction memory, one cycle after each
// accepted input.
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on state and clear, never on in_valid.
// The producer holds fields stable while in_valid is high and not yet accepted.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        dbg_state
);

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              hs;
  logic              wr_ok;
  logic              last_slot;

  rv_pack u_pack (
    .in_class (in_class),
    .funct3   (in_funct3),
    .f7b5     (in_f7b5),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .word     (pack_word),
    .illegal  (pack_illegal)
  );

  assign in_ready  = (state_q == ST_RUN) & ~clear;
  assign hs        = in_valid & in_ready;
  assign wr_ok     = hs & ~pack_illegal;
  assign last_slot = (wr_addr_q == {ADDR_W{1'b1}});
  assign count     = count_q;
  assign full      = count_q[ADDR_W];
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: FULL is entered on the handshake that fills the last slot, so
  // in_ready drops in the same cycle the final write appears. clear overrides all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (wr_ok && last_slot) state_d = ST_FULL;
      ST_FULL: state_d = ST_FULL;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // Registered write port, address/count bookkeeping and sticky error.
  // A pending write from the previous cycle is already on the outputs, so clear
  // only affects what happens from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      wr_addr_q  <= '0;
      count_q    <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= wr_ok;
      if (wr_ok) begin
        imem_addr  <= wr_addr_q;
        imem_wdata <= pack_word;
        wr_addr_q  <= wr_addr_q + 1'b1;
        count_q    <= count_q + 1'b1;
      end
      if (hs && pack_illegal) err <= 1'b1;
      if (clear) begin
        imem_addr <= '0;
        wr_addr_q <= '0;
        count_q   <= '0;
        err       <= 1'b0;
      end else if (start && state_q == ST_IDLE) begin
        wr_addr_q <= '0;
        count_q   <= '0;
      end
    end
  end

endmodule
